router_fsm_np: RTL and testbench
================================

# router_fsm_np

Parametrised packet-router control FSM for an N-output router. It sits between the register/synchroniser stage and the per-port output FIFOs. It decodes the header address against `NUM_PORTS` destinations, waits for the destination FIFO to empty, sequences the payload, full and parity phases, and drives per-state strobes to the datapath. New over the fixed three-port controller:

- the destination address is latched;
- soft reset applies only to the active destination;
- packets with an out-of-range address are dropped;
- the wait for an empty FIFO has a timeout;
- dropped packets are counted.

## Interface
- `NUM_PORTS`, 3: output channels, 2..16.
- `ADDR_W`, 2: header address width, `$clog2(NUM_PORTS)`, minimum 1.
- `WAIT_MAX`, 255: maximum cycles in WAIT_TILL_EMPTY before dropping; 0 disables the timeout.
- `CNT_W`, 8: drop counter width.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `pkt_valid` in 1: packet byte valid from source.
- `data_addr` in `ADDR_W`: address field of the current input byte; meaningful only in the header.
- `fifo_empty` in `NUM_PORTS`: per-port FIFO empty flags.
- `soft_reset` in `NUM_PORTS`: per-port soft reset pulses.
- `fifo_full` in 1: full flag of the selected FIFO.
- `low_pkt_valid` in 1: payload ended while full.
- `parity_done` in 1: parity byte has been written.
- `busy` out 1: stall the source.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `write_enb_reg`, `rst_int_reg`, `drop_state` out 1 each: state strobes.
- `dest_sel` out `NUM_PORTS`: one-hot active destination.
- `drop_count` out `CNT_W`: saturating count of dropped packets.

## Operation
- States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.
- State, `addr_q`, `wait_cnt` and `drop_count` are registers; next-state logic and outputs are combinational.
- All outputs are Moore (a function of state and `addr_q` only).

Address latch:
- `addr_q` <= `data_addr` only when in DECODE_ADDRESS with `pkt_valid`=1; otherwise it holds.
- WAIT_TILL_EMPTY tests `fifo_empty[addr_q]`, never the live `data_addr`.

Transitions:
- DECODE_ADDRESS, `pkt_valid`=0: stay.
- DECODE_ADDRESS, `pkt_valid`=1:
  - `data_addr` >= `NUM_PORTS` → DROP_PACKET;
  - else `fifo_empty[data_addr]`=1 → LOAD_FIRST_DATA;
  - else → WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY:
  - `fifo_empty[addr_q]`=1 → LOAD_FIRST_DATA;
  - else `WAIT_MAX`≠0 and `wait_cnt`==`WAIT_MAX`-1 → DROP_PACKET;
  - else stay with `wait_cnt`+1.
  - `wait_cnt` clears on every entry to the state.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA: `fifo_full` → FIFO_FULL_STATE; else `!pkt_valid` → LOAD_PARITY; else stay.
- FIFO_FULL_STATE: stay while `fifo_full`; else → LOAD_AFTER_FULL.
- LOAD_AFTER_FULL, in priority order: `parity_done` → DECODE_ADDRESS; `low_pkt_valid` → LOAD_PARITY; else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- DROP_PACKET: stay while `pkt_valid`; else → DECODE_ADDRESS.
- Illegal encodings → DECODE_ADDRESS.

Soft reset:
- `soft_reset[addr_q]`=1 in any state except DECODE_ADDRESS or DROP_PACKET forces DECODE_ADDRESS on the next edge.
- It overrides all transitions.
- Soft resets of other ports are ignored.

Drop counter:
- `drop_count` increments on every transition into DROP_PACKET.
- It saturates at all-ones and is cleared only by `resetn`.

Outputs per state (unlisted outputs are 0):
- DECODE_ADDRESS: `detect_add`.
- WAIT_TILL_EMPTY: `busy`.
- LOAD_FIRST_DATA: `lfd_state`, `busy`.
- LOAD_DATA: `ld_state`, `write_enb_reg`.
- LOAD_PARITY: `busy`, `write_enb_reg`.
- FIFO_FULL_STATE: `busy`, `full_state`.
- LOAD_AFTER_FULL: `laf_state`, `busy`, `write_enb_reg`.
- CHECK_PARITY_ERROR: `rst_int_reg`, `busy`.
- DROP_PACKET: `drop_state` only. `busy`=0, so the source drains the packet.

`dest_sel`:
- `dest_sel` = one-hot(`addr_q`) in WAIT_TILL_EMPTY through CHECK_PARITY_ERROR.
- `dest_sel` = 0 in DECODE_ADDRESS and DROP_PACKET.

## Timing
- Reset, asynchronous with `resetn`=0:
  - state = DECODE_ADDRESS; `addr_q`=0, `wait_cnt`=0, `drop_count`=0.
  - Outputs during and after reset: `detect_add`=1, all other outputs 0, `dest_sel`=0.
  - Reset release is sampled on the next rising edge.
- A header sampled in DECODE_ADDRESS with an empty destination gives `lfd_state`=1 one cycle later and `ld_state`=1 two cycles later.
- A header to a non-empty port shows `busy`=1 one cycle after the header edge. LOAD_FIRST_DATA follows one cycle after `fifo_empty[addr_q]` is sampled high.
- Timeout: with `WAIT_MAX`=W, DROP_PACKET is entered exactly W cycles after entering WAIT_TILL_EMPTY if the FIFO stays non-empty.
- Simultaneous `fifo_full` and `!pkt_valid` in LOAD_DATA: `fifo_full` wins.
- Simultaneous `parity_done` and `low_pkt_valid` in LOAD_AFTER_FULL: `parity_done` wins.
- A soft reset asserted in the same cycle as a timeout: soft reset wins, and `drop_count` does not increment.

## Test plan
- **Header to empty port.** `NUM_PORTS`=4, `resetn` released, header `data_addr`=2, `fifo_empty`=4'b1111, 3 payload cycles, then `pkt_valid`=0.
  - States: LFD, LD×3, LP, CPE, DECODE.
  - `dest_sel`=4'b0100 from LFD through CPE; `write_enb_reg` high in LD and LP.
- **Wait then proceed.** Header `data_addr`=1 with `fifo_empty[1]`=0 for 5 cycles, then 1.
  - `busy`=1 for 5 cycles, then `lfd_state`=1 on the following cycle.
  - `data_addr` toggling during the wait has no effect.
- **Timeout.** `WAIT_MAX`=8, `fifo_empty[0]` held at 0.
  - DROP_PACKET entered 8 cycles after WAIT; `busy`=0 and `drop_state`=1.
  - `drop_count`=1; DECODE reached once `pkt_valid` falls.
- **Illegal address.** `NUM_PORTS`=3, header `data_addr`=3.
  - Immediate DROP_PACKET, `dest_sel`=0, `drop_count` increments.
  - Further illegal headers saturate the counter at 255.
- **Full path.** `fifo_full`=1 during LD for 3 cycles, then 0 with `low_pkt_valid`=1.
  - Sequence: FULL×3, LAF, LP, CPE.
  - Repeat with `parity_done`=1 in LAF: returns straight to DECODE.
- **Soft reset and async reset.**
  - `soft_reset[1]` while routing to port 1 in LD: DECODE next cycle.
  - `soft_reset[0]` in the same situation: ignored.
  - `resetn` pulsed low mid-FULL without a clock edge: `detect_add`=1 immediately and all counters are 0.

Source files
------------

// File: rtl/router_fsm_np.sv
// router_fsm_np: header decode and payload sequencing control for an
// N-output packet router, with address latch, drop path and wait timeout.
module router_fsm_np #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = $clog2(NUM_PORTS),
    parameter int WAIT_MAX  = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_addr,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 fifo_full,
    input  logic                 low_pkt_valid,
    input  logic                 parity_done,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int EXT_W = 1 << ADDR_W;
    localparam int WC_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);
    localparam logic [ADDR_W:0] NPORTS    = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        WAIT_TILL_EMPTY    = 4'd1,
        LOAD_FIRST_DATA    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [EXT_W-1:0]  empty_ext;
    logic [EXT_W-1:0]  srst_ext;
    logic              hdr_legal;
    logic              soft_hit;

    // Pad per-port flags to the full address space so any address indexes safely
    assign empty_ext = EXT_W'(fifo_empty);
    assign srst_ext  = EXT_W'(soft_reset);
    assign hdr_legal = {1'b0, data_addr} < NPORTS;
    assign soft_hit  = srst_ext[addr_q]
                     && (state_q != DECODE_ADDRESS)
                     && (state_q != DROP_PACKET);

    // State and bookkeeping registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state selection; a soft reset of the active port overrides all arcs
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!hdr_legal)
                        state_d = DROP_PACKET;
                    else if (empty_ext[data_addr])
                        state_d = LOAD_FIRST_DATA;
                    else
                        state_d = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[addr_q])
                    state_d = LOAD_FIRST_DATA;
                else if ((WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST))
                    state_d = DROP_PACKET;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else
                    state_d = DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid)
                    state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        if (soft_hit)
            state_d = DECODE_ADDRESS;
    end

    // Address latch, wait timer (cleared whenever the wait is not continuing) and drop counter
    always_comb begin
        addr_d     = addr_q;
        wait_cnt_d = '0;
        drop_cnt_d = drop_cnt_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid)
            addr_d = data_addr;
        if ((state_q == WAIT_TILL_EMPTY) && (state_d == WAIT_TILL_EMPTY))
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        if ((state_d == DROP_PACKET) && (state_q != DROP_PACKET)
            && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // Moore strobes decoded from the current state and latched address
    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        drop_state    = 1'b0;
        dest_sel      = '0;
        unique case (state_q)
            DECODE_ADDRESS: detect_add = 1'b1;
            WAIT_TILL_EMPTY: begin
                busy     = 1'b1;
                dest_sel = NUM_PORTS'(1) << addr_q;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
                dest_sel  = NUM_PORTS'(1) << addr_q;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                dest_sel      = NUM_PORTS'(1) << addr_q;
            end
            FIFO_FULL_STATE: begin
                busy       = 1'b1;
                full_state = 1'b1;
                dest_sel   = NUM_PORTS'(1) << addr_q;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                dest_sel      = NUM_PORTS'(1) << addr_q;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                dest_sel      = NUM_PORTS'(1) << addr_q;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
                dest_sel    = NUM_PORTS'(1) << addr_q;
            end
            DROP_PACKET: drop_state = 1'b1;
            default: detect_add = 1'b1;
        endcase
    end

    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: directed vector table plus hand sequences for
// router_fsm_np with 3 ports and an 8-cycle wait timeout.
module tb_router_fsm_np;

    // strobe order: busy detect lfd ld laf full web rst_int drop
    localparam logic [8:0] SDA  = 9'b010000000;
    localparam logic [8:0] SWT  = 9'b100000000;
    localparam logic [8:0] SLFD = 9'b101000000;
    localparam logic [8:0] SLD  = 9'b000100100;
    localparam logic [8:0] SLP  = 9'b100000100;
    localparam logic [8:0] SFF  = 9'b100001000;
    localparam logic [8:0] SLAF = 9'b100010100;
    localparam logic [8:0] SCPE = 9'b100000010;
    localparam logic [8:0] SDR  = 9'b000000001;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_addr;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       fifo_full;
    logic       low_pkt_valid;
    logic       parity_done;
    logic       busy, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg, drop_state;
    logic [2:0] dest_sel;
    logic [7:0] drop_count;

    router_fsm_np #(
        .NUM_PORTS(3),
        .ADDR_W   (2),
        .WAIT_MAX (8),
        .CNT_W    (8)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_addr    (data_addr),
        .fifo_empty   (fifo_empty),
        .soft_reset   (soft_reset),
        .fifo_full    (fifo_full),
        .low_pkt_valid(low_pkt_valid),
        .parity_done  (parity_done),
        .busy         (busy),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg  (rst_int_reg),
        .drop_state   (drop_state),
        .dest_sel     (dest_sel),
        .drop_count   (drop_count)
    );

    typedef struct {
        string      nm;
        logic       pv;
        logic [1:0] ad;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       ff;
        logic       low;
        logic       pd;
        logic [8:0] strb;
        logic [2:0] dest;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string nm, logic pv, logic [1:0] ad,
                                logic [2:0] emp, logic [2:0] sr,
                                logic ff, logic low, logic pd,
                                logic [8:0] strb, logic [2:0] dest,
                                logic [7:0] cnt);
        vec_t v;
        v.nm = nm; v.pv = pv; v.ad = ad; v.emp = emp; v.sr = sr;
        v.ff = ff; v.low = low; v.pd = pd;
        v.strb = strb; v.dest = dest; v.cnt = cnt;
        return v;
    endfunction

    function automatic void add(string nm, logic pv, logic [1:0] ad,
                                logic [2:0] emp, logic [2:0] sr,
                                logic ff, logic low, logic pd,
                                logic [8:0] strb, logic [2:0] dest,
                                logic [7:0] cnt);
        tbl.push_back(mk(nm, pv, ad, emp, sr, ff, low, pd, strb, dest, cnt));
    endfunction

    task automatic check(string nm, logic [8:0] es, logic [2:0] ed,
                         logic [7:0] ec);
        logic [8:0] s;
        s = {busy, detect_add, lfd_state, ld_state, laf_state,
             full_state, write_enb_reg, rst_int_reg, drop_state};
        n_vec++;
        if (s !== es || dest_sel !== ed || drop_count !== ec) begin
            n_bad++;
            $display("FAIL %s: got strb=%b dest=%b cnt=%0d, want strb=%b dest=%b cnt=%0d",
                     nm, s, dest_sel, drop_count, es, ed, ec);
        end
    endtask

    task automatic apply(vec_t v);
        pkt_valid     = v.pv;
        data_addr     = v.ad;
        fifo_empty    = v.emp;
        soft_reset    = v.sr;
        fifo_full     = v.ff;
        low_pkt_valid = v.low;
        parity_done   = v.pd;
        @(posedge clock);
        #1;
        check(v.nm, v.strb, v.dest, v.cnt);
    endtask

    initial begin
        int cnt_m;
        // header to empty port 2
        add("hdr_lfd",   1, 2, 3'b111, 0, 0, 0, 0, SLFD, 3'b100, 0);
        add("ld1",       1, 2, 3'b111, 0, 0, 0, 0, SLD,  3'b100, 0);
        add("ld2",       1, 2, 3'b111, 0, 0, 0, 0, SLD,  3'b100, 0);
        add("ld3",       1, 2, 3'b111, 0, 0, 0, 0, SLD,  3'b100, 0);
        add("lp",        0, 2, 3'b111, 0, 0, 0, 0, SLP,  3'b100, 0);
        add("cpe",       0, 2, 3'b111, 0, 0, 0, 0, SCPE, 3'b100, 0);
        add("cpe_da",    0, 2, 3'b111, 0, 0, 0, 0, SDA,  3'b000, 0);
        // wait on port 1 while data_addr toggles
        add("wait1",     1, 1, 3'b101, 0, 0, 0, 0, SWT,  3'b010, 0);
        add("wait2",     1, 0, 3'b101, 0, 0, 0, 0, SWT,  3'b010, 0);
        add("wait3",     1, 2, 3'b101, 0, 0, 0, 0, SWT,  3'b010, 0);
        add("wait4",     1, 0, 3'b101, 0, 0, 0, 0, SWT,  3'b010, 0);
        add("wait5",     1, 3, 3'b101, 0, 0, 0, 0, SWT,  3'b010, 0);
        add("wait_lfd",  1, 0, 3'b111, 0, 0, 0, 0, SLFD, 3'b010, 0);
        // full path with low_pkt_valid
        add("lfd_ld",    1, 0, 3'b111, 0, 1, 0, 0, SLD,  3'b010, 0);
        add("full1",     1, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b010, 0);
        add("full2",     0, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b010, 0);
        add("full3",     0, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b010, 0);
        add("laf",       0, 0, 3'b111, 0, 0, 1, 0, SLAF, 3'b010, 0);
        add("laf_lp",    0, 0, 3'b111, 0, 0, 1, 0, SLP,  3'b010, 0);
        add("lp_cpe",    0, 0, 3'b111, 0, 0, 0, 0, SCPE, 3'b010, 0);
        add("cpe_da2",   0, 0, 3'b111, 0, 0, 0, 0, SDA,  3'b000, 0);
        // full beats !pkt_valid, parity_done beats low_pkt_valid
        add("p0_lfd",    1, 0, 3'b111, 0, 0, 0, 0, SLFD, 3'b001, 0);
        add("p0_ld",     0, 0, 3'b111, 0, 1, 0, 0, SLD,  3'b001, 0);
        add("ff_wins",   0, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b001, 0);
        add("p0_laf",    0, 0, 3'b111, 0, 0, 1, 1, SLAF, 3'b001, 0);
        add("pd_wins",   0, 0, 3'b111, 0, 0, 1, 1, SDA,  3'b000, 0);
        // LAF back to LD, CPE into FULL
        add("q_lfd",     1, 0, 3'b111, 0, 0, 0, 0, SLFD, 3'b001, 0);
        add("q_ld",      1, 0, 3'b111, 0, 0, 0, 0, SLD,  3'b001, 0);
        add("q_ff",      1, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b001, 0);
        add("q_laf",     1, 0, 3'b111, 0, 0, 0, 0, SLAF, 3'b001, 0);
        add("laf_ld",    1, 0, 3'b111, 0, 0, 0, 0, SLD,  3'b001, 0);
        add("q_lp",      0, 0, 3'b111, 0, 0, 0, 0, SLP,  3'b001, 0);
        add("lp_cpe_ff", 0, 0, 3'b111, 0, 1, 0, 0, SCPE, 3'b001, 0);
        add("cpe_ff",    0, 0, 3'b111, 0, 1, 0, 0, SFF,  3'b001, 0);
        add("q_laf2",    0, 0, 3'b111, 0, 0, 0, 0, SLAF, 3'b001, 0);
        add("q_da",      0, 0, 3'b111, 0, 0, 0, 1, SDA,  3'b000, 0);
        // timeout after exactly 8 cycles in wait
        add("to_wait",   1, 0, 3'b110, 0, 0, 0, 0, SWT,  3'b001, 0);
        for (int i = 0; i < 7; i++)
            add("to_hold", 1, 0, 3'b110, 0, 0, 0, 0, SWT, 3'b001, 0);
        add("to_drop",   1, 0, 3'b110, 0, 0, 0, 0, SDR,  3'b000, 1);
        add("drop_hold", 1, 0, 3'b110, 0, 0, 0, 0, SDR,  3'b000, 1);
        add("drop_da",   0, 0, 3'b110, 0, 0, 0, 0, SDA,  3'b000, 1);
        // illegal address
        add("bad_addr",  1, 3, 3'b111, 0, 0, 0, 0, SDR,  3'b000, 2);
        add("bad_da",    0, 3, 3'b111, 0, 0, 0, 0, SDA,  3'b000, 2);
        // soft reset on active port only
        add("sr_lfd",    1, 1, 3'b111, 3'b000, 0, 0, 0, SLFD, 3'b010, 2);
        add("sr_other1", 1, 1, 3'b111, 3'b001, 0, 0, 0, SLD,  3'b010, 2);
        add("sr_other2", 1, 1, 3'b111, 3'b001, 0, 0, 0, SLD,  3'b010, 2);
        add("sr_own",    1, 1, 3'b111, 3'b010, 0, 0, 0, SDA,  3'b000, 2);
        // soft reset beats a timeout in the same cycle
        add("srt_wait",  1, 1, 3'b101, 3'b000, 0, 0, 0, SWT,  3'b010, 2);
        for (int i = 0; i < 7; i++)
            add("srt_hold", 1, 0, 3'b101, 3'b000, 0, 0, 0, SWT, 3'b010, 2);
        add("sr_vs_to",  1, 0, 3'b101, 3'b010, 0, 0, 0, SDA,  3'b000, 2);
        // soft reset ignored in decode
        add("sr_in_da",  1, 2, 3'b111, 3'b010, 0, 0, 0, SLFD, 3'b100, 2);
        add("sr_lfd2",   1, 2, 3'b111, 3'b100, 0, 0, 0, SDA,  3'b000, 2);
        add("bad2",      1, 3, 3'b111, 3'b000, 0, 0, 0, SDR,  3'b000, 3);
        add("bad2_da",   0, 3, 3'b111, 3'b000, 0, 0, 0, SDA,  3'b000, 3);

        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_addr     = '0;
        fifo_empty    = 3'b111;
        soft_reset    = '0;
        fifo_full     = 1'b0;
        low_pkt_valid = 1'b0;
        parity_done   = 1'b0;
        #3;
        check("reset_async", SDA, 3'b000, 0);
        pkt_valid = 1'b1;
        data_addr = 2'd2;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_held", SDA, 3'b000, 0);
        pkt_valid = 1'b0;
        #3;
        resetn = 1'b1;

        foreach (tbl[i])
            apply(tbl[i]);

        // drop counter saturation via repeated illegal headers
        cnt_m = 3;
        for (int i = 0; i < 255; i++) begin
            cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
            apply(mk("sat_drop", 1, 3, 3'b111, 0, 0, 0, 0, SDR, 3'b000, 8'(cnt_m)));
            apply(mk("sat_da", 0, 3, 3'b111, 0, 0, 0, 0, SDA, 3'b000, 8'(cnt_m)));
        end

        // async reset mid-FULL without a clock edge
        apply(mk("ar_lfd", 1, 2, 3'b111, 0, 0, 0, 0, SLFD, 3'b100, 255));
        apply(mk("ar_ld", 1, 2, 3'b111, 0, 0, 0, 0, SLD, 3'b100, 255));
        apply(mk("ar_ff", 1, 2, 3'b111, 0, 1, 0, 0, SFF, 3'b100, 255));
        #3;
        resetn = 1'b0;
        #1;
        check("ar_immediate", SDA, 3'b000, 0);
        #2;
        resetn = 1'b1;
        apply(mk("ar_after", 0, 2, 3'b111, 0, 1, 0, 0, SDA, 3'b000, 0));
        apply(mk("ar_hdr", 1, 1, 3'b111, 0, 0, 0, 0, SLFD, 3'b010, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
